// File: rtl/wb_pkg.sv
// Shared writeback definitions: default widths, the r0 constant and the request record.
package wb_pkg;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_ADDR_W = 5;

  localparam logic [WB_ADDR_W-1:0] REG_ZERO = '0;

  // Register-file write request at the default widths.
  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO with occupancy count, head output and per-slot tag/valid export.
module wb_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DEPTH-1:0]         slot_valid,
  output logic [DEPTH*TAG_W-1:0]   slot_tags
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // One extra pointer bit separates full from empty when the low bits match.
  logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
  logic             push_en, pop_en;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  // A full FIFO refuses a push even if it pops in the same cycle.
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q[PTR_W-1:0]];

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage; contents are qualified by the pointers, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [PTR_W-1:0] off;
    assign off           = PTR_W'(i) - rd_ptr_q[PTR_W-1:0];
    assign slot_valid[i] = ({1'b0, off} < count);
    assign slot_tags[i*TAG_W +: TAG_W] = mem_q[i][WIDTH-1 -: TAG_W];
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Merges the pipeline result and buffered MDU results onto the single register-file write port.
module wb_write_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W       = WB_DATA_W,
  parameter int unsigned ADDR_W       = WB_ADDR_W,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pipe_valid,
  input  logic [ADDR_W-1:0]             pipe_addr,
  input  logic [DATA_W-1:0]             pipe_data,
  output logic                          pipe_stall,
  input  logic                          mdu_valid,
  output logic                          mdu_ready,
  input  logic [ADDR_W-1:0]             mdu_addr,
  input  logic [DATA_W-1:0]             mdu_data,
  output logic [ADDR_W-1:0]             write_register,
  output logic [DATA_W-1:0]             write_data,
  output logic                          write_enable,
  output logic [2**ADDR_W-1:0]          pending_mask,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned REQ_W    = ADDR_W + DATA_W;
  localparam int unsigned STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  req_t                       push_req, head_req, issue_req;
  logic                       fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [FIFO_DEPTH-1:0]      slot_valid;
  logic [FIFO_DEPTH*ADDR_W-1:0] slot_tags;
  logic                       pipe_win, issue_en;
  logic [STARVE_W-1:0]        starve_q, starve_d;

  assign push_req  = '{addr: mdu_addr, data: mdu_data};
  assign mdu_ready = ~fifo_full;
  // r0 results still complete the handshake but are dropped here.
  assign fifo_push = mdu_valid & ~fifo_full & (mdu_addr != ZERO_ADDR);
  assign pipe_win  = pipe_valid & (pipe_addr != ZERO_ADDR);

  wb_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH),
    .TAG_W (ADDR_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .push_data  (push_req),
    .pop        (fifo_pop),
    .head       (head_req),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .slot_valid (slot_valid),
    .slot_tags  (slot_tags)
  );

  // Pick one winner per cycle; the FIFO is forced after STARVE_LIMIT pipeline wins.
  always_comb begin
    pipe_stall = 1'b0;
    fifo_pop   = 1'b0;
    issue_en   = 1'b0;
    issue_req  = '{addr: pipe_addr, data: pipe_data};
    starve_d   = '0;
    if (!fifo_empty && (starve_q == STARVE_W'(STARVE_LIMIT))) begin
      pipe_stall = 1'b1;
      fifo_pop   = 1'b1;
      issue_en   = 1'b1;
      issue_req  = head_req;
    end else if (pipe_win) begin
      issue_en = 1'b1;
      starve_d = fifo_empty ? '0 : starve_q + STARVE_W'(1);
    end else if (!fifo_empty) begin
      fifo_pop  = 1'b1;
      issue_en  = 1'b1;
      issue_req = head_req;
    end
  end

  // Starvation counter and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q       <= '0;
      write_enable   <= 1'b0;
      write_register <= '0;
      write_data     <= '0;
    end else begin
      starve_q     <= starve_d;
      write_enable <= issue_en;
      if (issue_en) begin
        write_register <= issue_req.addr;
        write_data     <= issue_req.data;
      end
    end
  end

  // Destinations still owed to the register file: buffered entries plus the output stage.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (slot_valid[i]) pending_mask[slot_tags[i*ADDR_W +: ADDR_W]] = 1'b1;
    end
    if (write_enable) pending_mask[write_register] = 1'b1;
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: vector table plus multi-cycle sequences,
// with a write-port scoreboard fed in stimulus order.
module tb_wb_write_arbiter;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_valid, mdu_valid;
  logic [4:0]  pipe_addr, mdu_addr;
  logic [31:0] pipe_data, mdu_data;
  logic        pipe_stall, mdu_ready, write_enable;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic [31:0] pending_mask;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_fail   = 0;
  wb_req_t exp_q[$];

  always #5 clk = ~clk;

  wb_write_arbiter #(
    .DATA_W       (32),
    .ADDR_W       (5),
    .FIFO_DEPTH   (4),
    .STARVE_LIMIT (3)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pipe_valid     (pipe_valid),
    .pipe_addr      (pipe_addr),
    .pipe_data      (pipe_data),
    .pipe_stall     (pipe_stall),
    .mdu_valid      (mdu_valid),
    .mdu_ready      (mdu_ready),
    .mdu_addr       (mdu_addr),
    .mdu_data       (mdu_data),
    .write_register (write_register),
    .write_data     (write_data),
    .write_enable   (write_enable),
    .pending_mask   (pending_mask),
    .fifo_count     (fifo_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every observed write must match the next expected one.
  always @(negedge clk) begin
    if (rst_n && write_enable) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got r%0d=0x%0h, expected no write",
                 write_register, write_data);
      end else begin
        wb_req_t e;
        e = exp_q.pop_front();
        check("write_register", 64'(write_register), 64'(e.addr));
        check("write_data", 64'(write_data), 64'(e.data));
      end
    end
  end

  task automatic drive(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    pipe_valid = pv;
    pipe_addr  = pa;
    pipe_data  = pd;
    mdu_valid  = mv;
    mdu_addr   = ma;
    mdu_data   = md;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    wb_req_t r;
    r.addr = a;
    r.data = d;
    exp_q.push_back(r);
  endtask

  // One cycle: drive, check combinational outputs, clock, check occupancy.
  task automatic cycle(input string tag, input logic pv, input logic [4:0] pa,
                       input logic [31:0] pd, input logic mv, input logic [4:0] ma,
                       input logic [31:0] md, input logic exp_stall, input logic exp_ready,
                       input int exp_cnt);
    drive(pv, pa, pd, mv, ma, md);
    #1;
    check({tag, "_stall"}, 64'(pipe_stall), 64'(exp_stall));
    check({tag, "_ready"}, 64'(mdu_ready), 64'(exp_ready));
    @(posedge clk);
    #1;
    check({tag, "_count"}, 64'(fifo_count), 64'(exp_cnt));
  endtask

  typedef struct {
    logic        pv;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        we1;
    logic [2:0]  cnt1;
    logic [31:0] mask1;
    logic        we2;
    logic [31:0] mask2;
    int          nw;
    wb_req_t     w0;
    wb_req_t     w1;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single-cycle stimulus from idle; expectations for the next two cycles.
    vecs[0] = '{1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0,
                1'b1, 3'd0, 32'h20, 1'b0, 32'h0, 1, '{5'd5, 32'h1234}, '{5'd0, 32'h0}};
    vecs[1] = '{1'b1, 5'd0, 32'h5555, 1'b0, 5'd0, 32'h0,
                1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 0, '{5'd0, 32'h0}, '{5'd0, 32'h0}};
    vecs[2] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hDEAD,
                1'b0, 3'd1, 32'h200, 1'b1, 32'h200, 1, '{5'd9, 32'hDEAD}, '{5'd0, 32'h0}};
    vecs[3] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hBEEF,
                1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 0, '{5'd0, 32'h0}, '{5'd0, 32'h0}};
    vecs[4] = '{1'b1, 5'd7, 32'h77, 1'b1, 5'd3, 32'h33,
                1'b1, 3'd1, 32'h88, 1'b1, 32'h8, 2, '{5'd7, 32'h77}, '{5'd3, 32'h33}};
    vecs[5] = '{1'b1, 5'd0, 32'h66, 1'b1, 5'd12, 32'hC0C0,
                1'b0, 3'd1, 32'h1000, 1'b1, 32'h1000, 1, '{5'd12, 32'hC0C0}, '{5'd0, 32'h0}};

    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #2;
    check("rst_we", 64'(write_enable), 64'(0));
    check("rst_wr", 64'(write_register), 64'(0));
    check("rst_wd", 64'(write_data), 64'(0));
    check("rst_mask", 64'(pending_mask), 64'(0));
    check("rst_count", 64'(fifo_count), 64'(0));
    check("rst_stall", 64'(pipe_stall), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_ready", 64'(mdu_ready), 64'(1));
    check("idle_we", 64'(write_enable), 64'(0));

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].nw > 0) expect_wr(vecs[i].w0.addr, vecs[i].w0.data);
      if (vecs[i].nw > 1) expect_wr(vecs[i].w1.addr, vecs[i].w1.data);
      drive(vecs[i].pv, vecs[i].pa, vecs[i].pd, vecs[i].mv, vecs[i].ma, vecs[i].md);
      #1;
      check($sformatf("v%0d_ready", i), 64'(mdu_ready), 64'(1));
      check($sformatf("v%0d_stall", i), 64'(pipe_stall), 64'(0));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_we1", i), 64'(write_enable), 64'(vecs[i].we1));
      check($sformatf("v%0d_cnt1", i), 64'(fifo_count), 64'(vecs[i].cnt1));
      check($sformatf("v%0d_mask1", i), 64'(pending_mask), 64'(vecs[i].mask1));
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_we2", i), 64'(write_enable), 64'(vecs[i].we2));
      check($sformatf("v%0d_mask2", i), 64'(pending_mask), 64'(vecs[i].mask2));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_we3", i), 64'(write_enable), 64'(0));
      check($sformatf("v%0d_mask3", i), 64'(pending_mask), 64'(0));
      check($sformatf("v%0d_cnt3", i), 64'(fifo_count), 64'(0));
    end

    // Starvation: one buffered MDU result behind a continuous pipeline stream.
    expect_wr(5'd1, 32'h101);
    expect_wr(5'd2, 32'h102);
    expect_wr(5'd3, 32'h103);
    expect_wr(5'd4, 32'h104);
    expect_wr(5'd20, 32'hA5A5);
    expect_wr(5'd5, 32'h105);
    cycle("st0", 1'b1, 5'd1, 32'h101, 1'b1, 5'd20, 32'hA5A5, 1'b0, 1'b1, 1);
    cycle("st1", 1'b1, 5'd2, 32'h102, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1);
    cycle("st2", 1'b1, 5'd3, 32'h103, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1);
    cycle("st3", 1'b1, 5'd4, 32'h104, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1);
    cycle("st4", 1'b1, 5'd5, 32'h105, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 0);
    cycle("st5", 1'b1, 5'd5, 32'h105, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 0);
    cycle("st6", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 0);
    cycle("st7", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 0);

    // Fill to full under pipeline pressure; the push offered at full is refused.
    expect_wr(5'd1, 32'h201);
    expect_wr(5'd2, 32'h202);
    expect_wr(5'd3, 32'h203);
    expect_wr(5'd4, 32'h204);
    expect_wr(5'd21, 32'h3001);
    expect_wr(5'd5, 32'h205);
    expect_wr(5'd22, 32'h3002);
    expect_wr(5'd23, 32'h3003);
    expect_wr(5'd24, 32'h3004);
    cycle("fl0", 1'b1, 5'd1, 32'h201, 1'b1, 5'd21, 32'h3001, 1'b0, 1'b1, 1);
    cycle("fl1", 1'b1, 5'd2, 32'h202, 1'b1, 5'd22, 32'h3002, 1'b0, 1'b1, 2);
    cycle("fl2", 1'b1, 5'd3, 32'h203, 1'b1, 5'd23, 32'h3003, 1'b0, 1'b1, 3);
    cycle("fl3", 1'b1, 5'd4, 32'h204, 1'b1, 5'd24, 32'h3004, 1'b0, 1'b1, 4);
    check("fl3_mask", 64'(pending_mask), 64'(32'h01E0_0010));
    cycle("fl4", 1'b1, 5'd5, 32'h205, 1'b1, 5'd25, 32'h3005, 1'b1, 1'b0, 3);
    cycle("fl5", 1'b1, 5'd5, 32'h205, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 3);
    cycle("fl6", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 2);
    cycle("fl7", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1);
    cycle("fl8", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 0);
    cycle("fl9", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 0);

    // Reset while three MDU results are buffered and a write is in the output stage.
    expect_wr(5'd6, 32'h401);
    expect_wr(5'd7, 32'h402);
    cycle("rs0", 1'b1, 5'd6, 32'h401, 1'b1, 5'd26, 32'h5001, 1'b0, 1'b1, 1);
    cycle("rs1", 1'b1, 5'd7, 32'h402, 1'b1, 5'd27, 32'h5002, 1'b0, 1'b1, 2);
    cycle("rs2", 1'b1, 5'd8, 32'h403, 1'b1, 5'd28, 32'h5003, 1'b0, 1'b1, 3);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_count", 64'(fifo_count), 64'(0));
    check("mid_rst_we", 64'(write_enable), 64'(0));
    check("mid_rst_wr", 64'(write_register), 64'(0));
    check("mid_rst_mask", 64'(pending_mask), 64'(0));
    check("mid_rst_stall", 64'(pipe_stall), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", 64'(mdu_ready), 64'(1));
    check("post_rst_we", 64'(write_enable), 64'(0));
    check("post_rst_count", 64'(fifo_count), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle_we", 64'(write_enable), 64'(0));
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
